// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch feeding decode through a DEPTH-entry buffer.
// Optional macro FETCH_BYPASS_EN forwards a response straight to decode when the buffer is empty.
module fetch_unit #(
    parameter int DEPTH = 2,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc_addr,
    input  logic          branch_true,
    output logic          pc_enable,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [DW-1:0] imem_rdata,
    input  logic          id_stall,
    output logic          if_valid,
    output logic [DW-1:0] if_inst,
    output logic [AW-1:0] if_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t        state_r;
    logic [AW-1:0] req_pc_r;
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [DW-1:0] buf_inst_r [DEPTH];
    logic [AW-1:0] buf_pc_r   [DEPTH];

    logic req_s;
    logic grant_s;
    logic keep_s;
    logic bypass_s;
    logic push_s;
    logic pop_s;
    logic head_valid_s;

    // Request, handshake and buffer push/pop decode
    always_comb begin
        req_s        = (state_r == S_FETCH) && (count_r < DEPTH_C) && !branch_true;
        grant_s      = req_s && imem_gnt;
        keep_s       = (state_r == S_WAIT) && imem_rvalid && !branch_true;
        head_valid_s = (count_r != {CW{1'b0}});
`ifdef FETCH_BYPASS_EN
        bypass_s     = keep_s && !head_valid_s && !id_stall;
`else
        bypass_s     = 1'b0;
`endif
        push_s       = keep_s && !bypass_s;
        pop_s        = head_valid_s && !id_stall;
    end

    // Output drive, held low for the whole reset interval
    always_comb begin
        if (rst) begin
            imem_req  = 1'b0;
            pc_enable = 1'b0;
            imem_addr = {AW{1'b0}};
            if_valid  = 1'b0;
            if_inst   = {DW{1'b0}};
            if_pc     = {AW{1'b0}};
        end else begin
            imem_req  = req_s;
            pc_enable = grant_s | branch_true;
            imem_addr = pc_addr;
            if_valid  = head_valid_s | bypass_s;
            if (bypass_s) begin
                if_inst = imem_rdata;
                if_pc   = req_pc_r;
            end else begin
                if_inst = buf_inst_r[rd_ptr_r];
                if_pc   = buf_pc_r[rd_ptr_r];
            end
        end
    end

    // Fetch FSM: a redirect while a response is owed turns it into a discard
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= S_FETCH;
            req_pc_r <= {AW{1'b0}};
        end else begin
            case (state_r)
                S_FETCH: begin
                    if (grant_s) begin
                        req_pc_r <= pc_addr;
                        state_r  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state_r <= S_FETCH;
                    end else if (branch_true) begin
                        state_r <= S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (imem_rvalid) begin
                        state_r <= S_FETCH;
                    end
                end
                default: state_r <= S_FETCH;
            endcase
        end
    end

    // Buffer pointers and occupancy; a redirect empties the buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (branch_true) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Buffer storage needs no reset: entries are only read while counted valid
    always_ff @(posedge clk) begin
        if (push_s) begin
            buf_inst_r[wr_ptr_r] <= imem_rdata;
            buf_pc_r[wr_ptr_r]   <= req_pc_r;
        end
    end

    // Occupancy can never exceed the buffer depth
    count_le_depth: assert property (@(posedge clk) disable iff (rst) count_r <= DEPTH_C);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus random traffic checked every cycle against a
// queue-based model of the delivered instruction stream, a PC model and a memory model.
module tb_fetch_unit;
    localparam int DEPTH = 2;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc_addr;
    logic          branch_true;
    logic          pc_enable;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [DW-1:0] imem_rdata;
    logic          id_stall;
    logic          if_valid;
    logic [DW-1:0] if_inst;
    logic [AW-1:0] if_pc;

    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .pc_addr(pc_addr), .branch_true(branch_true),
        .pc_enable(pc_enable), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_stall(id_stall), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc)
    );

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] inst;
    } ent_t;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;
    int lat    = 1;   // latency given to the next grant; 0 picks 1..3 at random

    // Reference state: PC register, one-deep memory, instructions owed to decode
    logic [AW-1:0] m_pc   = '0;
    logic [AW-1:0] m_addr = '0;
    bit            m_pend = 1'b0;
    bit            m_keep = 1'b0;
    int            m_cnt  = 0;
    ent_t          q[$];

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return 32'hA5A5_0001 + (a * 32'h0001_0003);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    endtask

    task automatic cycle(input bit br, input logic [AW-1:0] tgt, input bit stall, input bit gnt);
        bit            e_req;
        bit            bypass;
        bit            e_valid;
        logic [AW-1:0] e_pc;
        logic [DW-1:0] e_inst;
        branch_true = br;
        id_stall    = stall;
        imem_gnt    = gnt;
        pc_addr     = rst ? 32'h0000_0123 : m_pc;
        imem_rvalid = m_pend && (m_cnt == 0);
        imem_rdata  = imem_rvalid ? mem_word(m_addr) : DW'($urandom);
        @(negedge clk);
        if (rst) begin
            chk("rst_imem_req", imem_req, 1'b0);
            chk("rst_pc_enable", pc_enable, 1'b0);
            chk("rst_if_valid", if_valid, 1'b0);
            chk("rst_imem_addr", imem_addr, 32'h0);
            chk("rst_if_inst", if_inst, 32'h0);
            chk("rst_if_pc", if_pc, 32'h0);
            q.delete();
            m_pend = 1'b0;
            m_keep = 1'b0;
            m_pc   = '0;
        end else begin
            e_req  = !m_pend && (q.size() < DEPTH) && !br;
            bypass = 1'b0;
`ifdef FETCH_BYPASS_EN
            bypass = imem_rvalid && m_keep && !br && (q.size() == 0) && !stall;
`endif
            e_valid = (q.size() != 0) || bypass;
            e_pc    = bypass ? m_addr : ((q.size() != 0) ? q[0].pc : '0);
            e_inst  = bypass ? mem_word(m_addr) : ((q.size() != 0) ? q[0].inst : '0);
            chk("imem_req", imem_req, e_req);
            chk("pc_enable", pc_enable, (e_req && gnt) || br);
            chk("imem_addr", imem_addr, m_pc);
            chk("if_valid", if_valid, e_valid);
            if (e_valid) begin
                chk("if_pc", if_pc, e_pc);
                chk("if_inst", if_inst, e_inst);
            end
            if (br) begin
                q.delete();
                m_keep = 1'b0;
            end else begin
                if ((q.size() != 0) && !stall) void'(q.pop_front());
                if (imem_rvalid && m_keep && !bypass) q.push_back(ent_t'{m_addr, mem_word(m_addr)});
            end
            if (imem_rvalid) m_pend = 1'b0;
            else if (m_pend) m_cnt--;
            if (e_req && gnt) begin
                m_pend = 1'b1;
                m_keep = 1'b1;
                m_addr = m_pc;
                m_cnt  = ((lat > 0) ? lat : int'($urandom_range(3, 1))) - 1;
            end
            if (br) m_pc = tgt;
            else if (e_req && gnt) m_pc = m_pc + 1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Let any owed response arrive without issuing new requests
    task automatic drain();
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        branch_true = 1'b0; id_stall = 1'b0; imem_gnt = 1'b1;
        imem_rvalid = 1'b0; imem_rdata = '0; pc_addr = '0;
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        rst = 1'b0;

        // First fetch from PC 0 with a one-cycle response
        lat = 1;
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        drain();

        // Stalled decode: buffer fills, requests stop, then resume in order
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        drain();

        // Redirect while a response is owed: the late response is dropped
        cycle(1'b1, 32'd4, 1'b0, 1'b0);
        lat = 3;
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b1, 32'd100, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        drain();

        // Redirect coincident with a response while one entry is buffered
        lat = 1;
        cycle(1'b1, 32'd200, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b1);
        cycle(1'b1, 32'd300, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0);
        drain();

        // Push and pop together with one entry held: decode sees a steady stream
        cycle(1'b1, 32'd400, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, '0, !(m_pend && (m_cnt == 0)), 1'b1);
            chk("steady_if_valid", if_valid, 1'b1);
        end
        drain();

        // Random traffic with random latency, including a reset mid-operation
        lat = 0;
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                rst = 1'b1;
                cycle(1'b0, '0, 1'b0, 1'b1);
                cycle(1'b0, '0, 1'b0, 1'b1);
                rst = 1'b0;
            end
            cycle(($urandom_range(99, 0) < 6), AW'($urandom_range(4095, 0)),
                  ($urandom_range(99, 0) < 35), ($urandom_range(99, 0) < 70));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage sitting directly downstream of the program counter. It drives the PC's advance enable, issues one word-addressed instruction-memory request at a time at the current PC, and buffers returned instructions with their PCs in a small FIFO feeding the IF/ID boundary. Branch redirects flush the buffer and discard any in-flight response.

## Interface
- `DEPTH`, 2: instruction buffer entries; power of two, ≥2.
- `AW`, 32: address/PC width.
- `DW`, 32: instruction width.

- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `pc_addr` in AW: current PC value (word address).
- `branch_true` in 1: redirect this cycle. The PC loads the new address on the same edge.
- `pc_enable` out 1: to PC; `(imem_req & imem_gnt) | branch_true`.
- `imem_req` out 1: fetch request.
- `imem_addr` out AW: equals `pc_addr`.
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1: response valid; arrives ≥1 cycle after grant.
- `imem_rdata` in DW: instruction data.
- `id_stall` in 1: decode cannot accept.
- `if_valid` out 1: instruction available to decode.
- `if_inst` out DW: instruction.
- `if_pc` out AW: PC of `if_inst`.

## Operation
- FSM states:
  - FETCH: nothing outstanding.
  - WAIT: one response owed, to be kept.
  - DISCARD: one response owed, to be dropped.
- `imem_req` = state==FETCH & count<DEPTH & !branch_true.
  - Request may be withdrawn before grant only because of `branch_true`.
- On grant:
  - `req_pc` ← `pc_addr`.
  - FETCH→WAIT.
  - `pc_enable` pulses for that cycle only.
- WAIT:
  - `imem_rvalid` & !branch_true: push {`req_pc`, `imem_rdata`}; →FETCH.
  - `branch_true` & `imem_rvalid`: drop the response; →FETCH.
  - `branch_true` & !`imem_rvalid`: →DISCARD.
- DISCARD:
  - `imem_rvalid`: drop; →FETCH.
  - `branch_true` stays DISCARD.
- FIFO head drives `if_inst`/`if_pc`; `if_valid` = count≠0.
- Pop on `if_valid & !id_stall`.
  - Push and pop in the same cycle leave count unchanged.
- `branch_true` (any state):
  - Count ← 0 and pointers ← 0, taking priority over push and pop.
  - `if_valid` is 0 the following cycle.
  - `pc_enable` is 1 so the PC loads the target.
- Overflow is impossible: an issue requires count<DEPTH and only one request is ever outstanding. Assert count≤DEPTH in simulation.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.

## Timing
- Reset: state FETCH, count/pointers 0, `req_pc` 0.
- While `rst` is high, all outputs are forced 0: `imem_req`, `pc_enable`, `if_valid`, `imem_addr`, `if_inst`, `if_pc`.
- Reset mid-operation abandons any outstanding response. The memory must be reset together with this block.
- Request latency:
  - `imem_req` is asserted combinationally in the cycle the FIFO has room.
  - The earliest next request is the cycle after the response.
- Fetch-to-decode latency without bypass: grant at cycle N, rvalid at N+k, `if_valid` at N+k+1.
- PC timing: the PC shows pc+1 in the cycle after the grant. `imem_addr` is therefore never reused.

## Configuration
- `FETCH_BYPASS_EN` defined:
  - Applies when FIFO count==0, state WAIT, `imem_rvalid`, !branch_true and !id_stall.
  - `if_valid`=1, `if_inst`=`imem_rdata` and `if_pc`=`req_pc` combinationally in the response cycle; nothing is pushed.
  - Otherwise the response is pushed as normal.
  - Latency becomes N+k.
- Undefined: every response goes through the FIFO. All outputs are registered-path only.

## Test plan
- Reset, then `pc_addr`=0, gnt same cycle, rvalid k=1 with data 0xA5A5_0001 → `if_valid` cycle N+2 with inst 0xA5A5_0001, pc 0; `pc_enable` high exactly at N.
- Hold `id_stall`=1, always grant, rvalid k=1, DEPTH=2 → two entries (pc 0, 1) fill, then `imem_req` stays 0. Release stall → pops in order pc 0 then 1, and requests resume.
- Grant at pc 4, then `branch_true` at N+1 with rvalid delayed to N+3 → state DISCARD, data at N+3 dropped, `if_valid` stays 0, next request issues from the new PC at N+4.
- `branch_true` in the same cycle as rvalid, with one entry buffered → entry flushed, response dropped, `if_valid`=0 next cycle, `pc_enable`=1 that cycle.
- Simultaneous push and pop with count=1 over 8 cycles → count constant 1; if_pc sequence increments by 1 with no duplicates or skips.
- `FETCH_BYPASS_EN` defined, empty FIFO, rvalid with data 0x1234_5678 → `if_valid`=1 with that inst in the same cycle; with `id_stall`=1 instead, it appears the next cycle from the FIFO.
